// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, ALU/mux selects,
// state codes and the strobe bundle decoded from the current state.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SLTI  = 4'b0011;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0110;

  // ALUOp encoding is shared with ALUControl
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REG = 2'b00,
    SRCB_ONE = 2'b01,
    SRCB_IMM = 2'b10
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsource_e;

  localparam logic [3:0] ST_RESET_IDLE = 4'd0;
  localparam logic [3:0] ST_FETCH      = 4'd1;
  localparam logic [3:0] ST_DECODE     = 4'd2;
  localparam logic [3:0] ST_EXEC_R     = 4'd3;
  localparam logic [3:0] ST_EXEC_I     = 4'd4;
  localparam logic [3:0] ST_MEM_ADDR   = 4'd5;
  localparam logic [3:0] ST_MEM_READ   = 4'd6;
  localparam logic [3:0] ST_MEM_WRITE  = 4'd7;
  localparam logic [3:0] ST_WB_R       = 4'd8;
  localparam logic [3:0] ST_WB_I       = 4'd9;
  localparam logic [3:0] ST_WB_MEM     = 4'd10;
  localparam logic [3:0] ST_BRANCH     = 4'd11;
  localparam logic [3:0] ST_JUMP       = 4'd12;

  typedef struct packed {
    logic      pc_write;
    logic      pc_write_cond;
    logic      iord;
    logic      mem_read;
    logic      mem_write;
    logic      ir_write;
    logic      mem_to_reg;
    logic      reg_dst;
    logic      reg_write;
    logic      alu_src_a;
    aluop_e    alu_op;
    alusrcb_e  alu_src_b;
    pcsource_e pc_source;
    logic      illegal;
    logic      mem_fault;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default:                                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Instruction/memory-handshake inputs and datapath control outputs of the control unit.
interface multicycle_control_fsm_if;

  logic [3:0] Opcode;
  logic [3:0] FunctIn;
  logic       MemReady;
  logic [1:0] ALUOp;
  logic [3:0] Funct;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       Illegal;
  logic       MemFault;
  logic [3:0] State;

  modport master (
    input  Opcode, FunctIn, MemReady,
    output ALUOp, Funct, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, Illegal,
           MemFault, State
  );

  modport slave (
    output Opcode, FunctIn, MemReady,
    input  ALUOp, Funct, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, Illegal,
           MemFault, State
  );

endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts memory wait cycles in a wait state; flags completion or timeout.
// The count is zero in the first cycle of every wait state.
module mem_wait_timer #(
  parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic active,
  input  logic mem_ready,
  output logic done,
  output logic timeout
);

  logic [3:0] cnt_r;

  // Completion has priority over a timeout landing on the same cycle
  assign done    = active & mem_ready;
  assign timeout = active & ~mem_ready & (cnt_r == MEM_TIMEOUT);

  // Wait counter: advances only while still waiting, otherwise returns to zero
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_r <= 4'd0;
    end else if (active && !mem_ready && !timeout) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= 4'd0;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main control: fetch/decode/execute/memory/writeback sequencing
// with a bounded wait on the shared memory.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  multicycle_control_fsm_if.master bus
);

  logic [3:0] state_r;
  logic [3:0] state_nx_s;
  logic [3:0] op_r;
  logic [3:0] funct_r;
  logic       wait_active_s;
  logic       mem_done_s;
  logic       mem_timeout_s;
  ctrl_t      ctrl_s;

  assign wait_active_s = (state_r == ST_FETCH) || (state_r == ST_MEM_READ) ||
                         (state_r == ST_MEM_WRITE);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .active    (wait_active_s),
    .mem_ready (bus.MemReady),
    .done      (mem_done_s),
    .timeout   (mem_timeout_s)
  );

  // State register plus opcode/funct captured while the IR is decoded
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_RESET_IDLE;
      op_r    <= 4'd0;
      funct_r <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      if (state_r == ST_DECODE) begin
        op_r    <= bus.Opcode;
        funct_r <= (bus.Opcode == OP_RTYPE) ? bus.FunctIn : 4'b0000;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_RESET_IDLE: state_nx_s = ST_FETCH;
      ST_FETCH: begin
        if (mem_done_s) state_nx_s = ST_DECODE;
        else            state_nx_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (bus.Opcode)
          OP_RTYPE:        state_nx_s = ST_EXEC_R;
          OP_ADDI, OP_SLTI: state_nx_s = ST_EXEC_I;
          OP_LW, OP_SW:    state_nx_s = ST_MEM_ADDR;
          OP_BEQ:          state_nx_s = ST_BRANCH;
          OP_J:            state_nx_s = ST_JUMP;
          default:         state_nx_s = ST_FETCH;
        endcase
      end
      ST_EXEC_R: state_nx_s = ST_WB_R;
      ST_EXEC_I: state_nx_s = ST_WB_I;
      ST_MEM_ADDR: begin
        if (op_r == OP_LW) state_nx_s = ST_MEM_READ;
        else               state_nx_s = ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        if (mem_done_s)         state_nx_s = ST_WB_MEM;
        else if (mem_timeout_s) state_nx_s = ST_FETCH;
        else                    state_nx_s = ST_MEM_READ;
      end
      ST_MEM_WRITE: begin
        if (mem_done_s || mem_timeout_s) state_nx_s = ST_FETCH;
        else                             state_nx_s = ST_MEM_WRITE;
      end
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_nx_s = ST_FETCH;
      default: state_nx_s = ST_RESET_IDLE;
    endcase
  end

  // Output decode; FETCH write strobes are qualified by MemReady
  always_comb begin
    ctrl_s           = '0;
    ctrl_s.mem_fault = mem_timeout_s;
    case (state_r)
      ST_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = SRCB_ONE;
        ctrl_s.ir_write  = bus.MemReady;
        ctrl_s.pc_write  = bus.MemReady;
      end
      ST_DECODE: begin
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.illegal   = ~is_legal_op(bus.Opcode);
      end
      ST_EXEC_R: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REG;
        ctrl_s.alu_op    = ALUOP_RTYPE;
      end
      ST_EXEC_I: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        if (op_r == OP_SLTI) ctrl_s.alu_op = ALUOP_SLT;
        else                 ctrl_s.alu_op = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        ctrl_s.iord     = 1'b1;
        ctrl_s.mem_read = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl_s.iord      = 1'b1;
        ctrl_s.mem_write = 1'b1;
      end
      ST_WB_R: begin
        ctrl_s.reg_dst   = 1'b1;
        ctrl_s.reg_write = 1'b1;
      end
      ST_WB_I:   ctrl_s.reg_write = 1'b1;
      ST_WB_MEM: begin
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_s.alu_src_a     = 1'b1;
        ctrl_s.alu_src_b     = SRCB_REG;
        ctrl_s.alu_op        = ALUOP_SUB;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.pc_source = PCSRC_JUMP;
      end
      default: ctrl_s = '0;
    endcase
  end

  assign bus.ALUOp       = ctrl_s.alu_op;
  assign bus.Funct       = funct_r;
  assign bus.PCWrite     = ctrl_s.pc_write;
  assign bus.PCWriteCond = ctrl_s.pc_write_cond;
  assign bus.IorD        = ctrl_s.iord;
  assign bus.MemRead     = ctrl_s.mem_read;
  assign bus.MemWrite    = ctrl_s.mem_write;
  assign bus.IRWrite     = ctrl_s.ir_write;
  assign bus.MemToReg    = ctrl_s.mem_to_reg;
  assign bus.RegDst      = ctrl_s.reg_dst;
  assign bus.RegWrite    = ctrl_s.reg_write;
  assign bus.ALUSrcA     = ctrl_s.alu_src_a;
  assign bus.ALUSrcB     = ctrl_s.alu_src_b;
  assign bus.PCSource    = ctrl_s.pc_source;
  assign bus.Illegal     = ctrl_s.illegal;
  assign bus.MemFault    = ctrl_s.mem_fault;
  assign bus.State       = state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle state and strobe checks
// against hand-computed expectations.
module tb_multicycle_control_fsm;

  // Expected-strobe masks; packed as in obs_s below
  localparam logic [17:0] PCW   = 18'h20000;
  localparam logic [17:0] PCWC  = 18'h10000;
  localparam logic [17:0] IORD  = 18'h08000;
  localparam logic [17:0] MRD   = 18'h04000;
  localparam logic [17:0] MWR   = 18'h02000;
  localparam logic [17:0] IRW   = 18'h01000;
  localparam logic [17:0] M2R   = 18'h00800;
  localparam logic [17:0] RDST  = 18'h00400;
  localparam logic [17:0] RWR   = 18'h00200;
  localparam logic [17:0] SRCA  = 18'h00100;
  localparam logic [17:0] SRCB2 = 18'h00080;
  localparam logic [17:0] SRCB1 = 18'h00040;
  localparam logic [17:0] PCS2  = 18'h00020;
  localparam logic [17:0] PCS1  = 18'h00010;
  localparam logic [17:0] AOP3  = 18'h0000C;
  localparam logic [17:0] AOP2  = 18'h00008;
  localparam logic [17:0] AOP1  = 18'h00004;
  localparam logic [17:0] ILL   = 18'h00002;
  localparam logic [17:0] FLT   = 18'h00001;
  localparam logic [17:0] NONE  = 18'h00000;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DEC = 4'd2,  S_EXR = 4'd3;
  localparam logic [3:0] S_EXI  = 4'd4,  S_MADDR = 4'd5,  S_MRD = 4'd6,  S_MWR = 4'd7;
  localparam logic [3:0] S_WBR  = 4'd8,  S_WBI   = 4'd9,  S_WBM = 4'd10, S_BR  = 4'd11;
  localparam logic [3:0] S_JMP  = 4'd12;

  logic        clk;
  logic        rst_n;
  logic [17:0] obs_s;
  int          tests_run;
  int          tests_failed;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.MEM_TIMEOUT(4'd15)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  assign obs_s = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.Illegal, bus.MemFault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (obs !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive MemReady, check state and strobes, advance to next negedge
  task automatic cyc(input string tag, input logic mr, input logic [3:0] st,
                     input logic [17:0] ex);
    bus.MemReady = mr;
    #1;
    check({tag, "_state"}, {28'd0, bus.State}, {28'd0, st});
    check(tag, {14'd0, obs_s}, {14'd0, ex});
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.Opcode   = 4'b0000;
    bus.FunctIn  = 4'b0000;
    bus.MemReady = 1'b1;

    // Reset held, MemReady high must not matter
    @(negedge clk); #1;
    check("rst_state", {28'd0, bus.State}, 32'd0);
    check("rst_out",   {14'd0, obs_s},     32'd0);
    check("rst_funct", {28'd0, bus.Funct}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.MemReady = 1'b0;
    #1;
    check("rel_state", {28'd0, bus.State}, {28'd0, S_IDLE});
    check("rel_out",   {14'd0, obs_s},     32'd0);
    @(negedge clk);

    // R-type, MemReady high in non-wait states is ignored
    bus.Opcode = 4'b0000; bus.FunctIn = 4'b1110;
    cyc("r_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("r_dec",   1'b1, S_DEC,   SRCB2);
    check("r_funct", {28'd0, bus.Funct}, 32'h0000_000E);
    cyc("r_exec",  1'b1, S_EXR,   SRCA | AOP2);
    cyc("r_wb",    1'b0, S_WBR,   RDST | RWR);

    // ADDI
    bus.Opcode = 4'b0010; bus.FunctIn = 4'b1011;
    cyc("addi_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("addi_dec",   1'b0, S_DEC,   SRCB2);
    check("addi_funct", {28'd0, bus.Funct}, 32'd0);
    cyc("addi_exec",  1'b0, S_EXI,   SRCA | SRCB2);
    cyc("addi_wb",    1'b0, S_WBI,   RWR);

    // SLTI
    bus.Opcode = 4'b0011;
    cyc("slti_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("slti_dec",   1'b0, S_DEC,   SRCB2);
    cyc("slti_exec",  1'b0, S_EXI,   SRCA | SRCB2 | AOP3);
    cyc("slti_wb",    1'b0, S_WBI,   RWR);

    // LW with three memory wait cycles
    bus.Opcode = 4'b1000;
    cyc("lw_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("lw_dec",   1'b0, S_DEC,   SRCB2);
    cyc("lw_addr",  1'b0, S_MADDR, SRCA | SRCB2);
    for (int i = 0; i < 3; i++) cyc("lw_wait", 1'b0, S_MRD, IORD | MRD);
    cyc("lw_read",  1'b1, S_MRD,   IORD | MRD);
    cyc("lw_wb",    1'b0, S_WBM,   M2R | RWR);

    // SW
    bus.Opcode = 4'b1001;
    cyc("sw_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("sw_dec",   1'b0, S_DEC,   SRCB2);
    cyc("sw_addr",  1'b0, S_MADDR, SRCA | SRCB2);
    cyc("sw_write", 1'b1, S_MWR,   IORD | MWR);

    // BEQ
    bus.Opcode = 4'b0100;
    cyc("beq_fetch",  1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("beq_dec",    1'b0, S_DEC,   SRCB2);
    cyc("beq_branch", 1'b0, S_BR,    SRCA | AOP1 | PCWC | PCS1);

    // J
    bus.Opcode = 4'b0110;
    cyc("j_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("j_dec",   1'b0, S_DEC,   SRCB2);
    cyc("j_jump",  1'b0, S_JMP,   PCW | PCS2);

    // Illegal opcode, then a FETCH that never sees MemReady
    bus.Opcode = 4'b1111;
    cyc("ill_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("ill_dec",   1'b0, S_DEC,   SRCB2 | ILL);
    for (int i = 0; i < 15; i++) cyc("to_wait", 1'b0, S_FETCH, MRD | SRCB1);
    cyc("to_fault", 1'b0, S_FETCH, MRD | SRCB1 | FLT);

    // Restarted FETCH; MemReady lands exactly on the timeout cycle
    bus.Opcode = 4'b0110;
    for (int i = 0; i < 15; i++) cyc("edge_wait", 1'b0, S_FETCH, MRD | SRCB1);
    cyc("edge_ready", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("edge_dec",   1'b0, S_DEC,   SRCB2);
    cyc("edge_jump",  1'b0, S_JMP,   PCW | PCS2);

    // LW whose read times out: no writeback
    bus.Opcode = 4'b1000;
    cyc("lwto_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("lwto_dec",   1'b0, S_DEC,   SRCB2);
    cyc("lwto_addr",  1'b0, S_MADDR, SRCA | SRCB2);
    for (int i = 0; i < 15; i++) cyc("lwto_wait", 1'b0, S_MRD, IORD | MRD);
    cyc("lwto_fault", 1'b0, S_MRD,   IORD | MRD | FLT);
    cyc("lwto_refetch", 1'b0, S_FETCH, MRD | SRCB1);

    // Reset asserted mid-instruction
    @(negedge clk);
    bus.Opcode = 4'b0000; bus.FunctIn = 4'b0101;
    cyc("mid_fetch", 1'b1, S_FETCH, MRD | IRW | PCW | SRCB1);
    cyc("mid_dec",   1'b0, S_DEC,   SRCB2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {28'd0, bus.State}, {28'd0, S_IDLE});
    check("mid_rst_out",   {14'd0, obs_s},     32'd0);
    check("mid_rst_funct", {28'd0, bus.Funct}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_state", {28'd0, bus.State}, {28'd0, S_IDLE});
    @(negedge clk);
    cyc("mid_refetch", 1'b0, S_FETCH, MRD | SRCB1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
